// File: rtl/fp_issue_queue.sv
// Command FIFO and single-outstanding issue controller in front of float_alu.
// Commands are queued, issued one at a time, and their results are held on a valid/ready port.
module fp_issue_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_round,
    input  logic             cmd_fp,
    output logic             alu_start,
    output logic [31:0]      alu_op_a,
    output logic [31:0]      alu_op_b,
    output logic [2:0]       alu_op_code,
    output logic             alu_round_mode,
    output logic             alu_mode_fp,
    output logic             alu_ready_in,
    input  logic             alu_ready_out,
    input  logic             alu_valid_out,
    input  logic [31:0]      alu_result,
    input  logic [4:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [4:0]       rsp_flags,
    output logic [4:0]       sticky_flags,
    input  logic             clear_flags,
    output logic [PTR_W:0]   count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        rnd;
        logic        fp;
    } cmd_t;

    cmd_t             mem [DEPTH];
    cmd_t             head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [1:0]       state;
    logic             push, pop, capture;

    // Ready and occupancy come from registered state only, so a pop never frees a full slot early.
    assign cmd_ready    = (count != FULL);
    assign alu_ready_in = (state == WAIT);
    assign head         = mem[rd_ptr];
    assign push         = cmd_valid && cmd_ready;
    assign pop          = (state == IDLE) && (count != '0) && alu_ready_out;
    // A result arriving while start is still high belongs to no issued op yet.
    assign capture      = (state == WAIT) && alu_valid_out && !alu_start;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{cmd_a, cmd_b, cmd_op, cmd_round, cmd_fp};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            state          <= IDLE;
            alu_start      <= 1'b0;
            alu_op_a       <= '0;
            alu_op_b       <= '0;
            alu_op_code    <= '0;
            alu_round_mode <= 1'b0;
            alu_mode_fp    <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_result     <= '0;
            rsp_flags      <= '0;
            sticky_flags   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + (PTR_W+1)'(1);
            else if (pop && !push) count <= count - (PTR_W+1)'(1);

            alu_start <= 1'b0;
            case (state)
                IDLE: if (pop) begin
                    alu_op_a       <= head.a;
                    alu_op_b       <= head.b;
                    alu_op_code    <= head.op;
                    alu_round_mode <= head.rnd;
                    alu_mode_fp    <= head.fp;
                    alu_start      <= 1'b1;
                    state          <= WAIT;
                end
                WAIT: if (capture) begin
                    rsp_result <= alu_result;
                    rsp_flags  <= alu_flags;
                    rsp_valid  <= 1'b1;
                    state      <= HOLD;
                end
                HOLD: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A clear coinciding with a capture keeps only the new flags.
            if (capture)          sticky_flags <= clear_flags ? alu_flags : (sticky_flags | alu_flags);
            else if (clear_flags) sticky_flags <= '0;
        end
    end

endmodule

// File: doc/fp_issue_queue.md
# fp_issue_queue

Command buffer and issue controller that sits directly upstream of `float_alu`. It accepts floating-point operation commands from the instruction side into a DEPTH-entry FIFO. It issues them to the ALU one at a time through the ALU's start/ready_out handshake, and collects each result and its flags. It presents each result on a valid/ready response port and keeps sticky exception flags.

## Interface
- `DEPTH`, 4: FIFO entries; must be a power of two, at least 2.
- `PTR_W`, 2: log2(DEPTH).
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  high when count < DEPTH.
- `cmd_a`, `cmd_b`  in  32 each  operands.
- `cmd_op`  in  3  opcode, passed through unchanged.
- `cmd_round`  in  1  rounding mode; 0 = nearest even.
- `cmd_fp`  in  1  precision mode; 1 = single.
- `alu_start`  out  1  one-cycle start pulse to the ALU.
- `alu_op_a`, `alu_op_b`  out  32 each  registered operands.
- `alu_op_code`  out  3  registered opcode.
- `alu_round_mode`, `alu_mode_fp`  out  1 each  registered modes.
- `alu_ready_in`  out  1  response slot free; high only in WAIT.
- `alu_ready_out`  in  1  ALU can accept a start.
- `alu_valid_out`  in  1  ALU result valid.
- `alu_result`  in  32  ALU result.
- `alu_flags`  in  5  ALU flags.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_result`  out  32  captured result.
- `rsp_flags`  out  5  captured flags.
- `sticky_flags`  out  5  OR of the flags of all responses since reset or clear.
- `clear_flags`  in  1  synchronous clear of `sticky_flags`.
- `count`  out  PTR_W+1  FIFO occupancy.

## Operation
- FIFO:
  - Push when cmd_valid && cmd_ready; entry = {a, b, op, round, fp}.
  - Pop on issue.
  - Read and write pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave `count` unchanged.
  - No bypass: a command pushed at edge N can issue at edge N+1 at the earliest.
  - When full, `cmd_ready` = 0 even if a pop occurs that cycle.
- FSM states: IDLE, WAIT, HOLD; reset state is IDLE.
  - IDLE: if count != 0 && alu_ready_out at an edge, then load head into `alu_op_*`/modes, alu_start <= 1, pop, go to WAIT. Otherwise stay.
  - WAIT: alu_start <= 0 at the first edge, so start is high exactly one cycle. `alu_ready_in` = 1. On an edge with `alu_valid_out`:
    - rsp_result <= alu_result
    - rsp_flags <= alu_flags
    - rsp_valid <= 1
    - go to HOLD.
  - `alu_valid_out` is ignored outside WAIT and in the cycle `alu_start` is high.
  - HOLD: response stable while rsp_valid && !rsp_ready. On an edge with rsp_ready, rsp_valid <= 0 and go to IDLE.
- Exactly one operation is outstanding at a time; results leave in command order.
- `alu_op_*`/modes hold their last issued value between operations.
- Sticky flags:
  - On capture: sticky <= sticky | alu_flags.
  - clear_flags alone: sticky <= 0.
  - clear_flags with capture in the same cycle: sticky <= alu_flags.
- Reset: asynchronous and immediate.
  - All outputs are 0 except `cmd_ready` = 1.
  - count = 0, pointers = 0, state = IDLE.
  - Reset mid-operation discards both the FIFO contents and the in-flight op. The ALU shares `rst_n`.

## Timing
- Issue latency: command accepted at edge N into an empty FIFO with IDLE and alu_ready_out = 1 gives alu_start high from edge N+1 to N+2.
- Response latency: `rsp_valid` rises at the edge that samples `alu_valid_out` in WAIT.
- Next issue: the earliest is the edge after the response is accepted (HOLD→IDLE, then IDLE issues).
- `cmd_ready` and `count` are combinational from registered state only; no combinational path from `cmd_valid`.
- `alu_ready_in` depends on state only.

## Test plan
- Single op: push {41A6_0000, 4010_0000, 010, round 0, fp 1}; ALU model returns 41B8_0000 after 3 cycles. Expect one alu_start pulse with those operands, then rsp_result = 41B8_0000 and count back to 0.
- Back-to-back order: push 5 commands; expect cmd_ready = 0 after the 4th until the first pop. With sums 41B8_0000, 3FE0_0000, 4183_0000, 41BE_0000, 41CA_3D70, expect responses in that exact order.
- Backpressure: hold rsp_ready = 0 for 10 cycles. Expect the response stable, no new alu_start, and alu_ready_in = 0; then one rsp_ready cycle releases it.
- ALU not ready: alu_ready_out = 0 with FIFO non-empty. Expect no start until it rises; start follows on the next edge.
- Sticky flags: responses with flags 00001 then 10000 give sticky = 10001. clear_flags coincident with a 00100 capture gives 00100.
- Reset mid-op: assert rst_n = 0 during WAIT with 2 entries queued. Expect all outputs at reset values immediately. After release, expect no alu_start and count = 0.
